// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: filters committed control-flow records into a FIFO, drains them to the BTB, and runs invalidate sweeps
module btb_update_ctrl #(
  parameter int BTB_DEPTH    = 32,
  parameter int BTB_IDX_BITS = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cm_valid,
  output logic                    cm_ready,
  input  logic [31:0]             cm_pc,
  input  logic [31:0]             cm_target,
  input  logic                    cm_is_br,
  input  logic                    cm_is_jal,
  input  logic                    cm_taken,
  input  logic                    inv_req,
  output logic                    inv_busy,
  output logic                    btb_wr_en,
  input  logic                    btb_wr_ready,
  output logic [31:0]             btb_wr_pc,
  output logic [31:0]             btb_wr_target,
  output logic                    btb_wr_taken,
  output logic                    btb_wr_jal,
  output logic                    btb_clr_en,
  output logic [BTB_IDX_BITS-1:0] btb_clr_idx,
  output logic                    fetch_hold,
  output logic [7:0]              drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = PW + 2;
  localparam logic [BTB_IDX_BITS-1:0] IDX_LAST = BTB_IDX_BITS'(BTB_DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                  r_state;
  logic [PW:0]             r_wp, r_rp;
  logic [65:0]             r_mem [FIFO_DEPTH];
  logic [BTB_IDX_BITS-1:0] r_idx;
  logic [7:0]              r_drop;
  logic                    w_clear, w_full, w_empty, w_cf, w_deq, w_flush, w_enq;
  logic [PW:0]             w_cnt;
  logic [65:0]             w_head, w_rec;
  logic [AW-1:0]           w_add;
  logic [8:0]              w_sum;
  assign w_clear = r_state == CLEAR;
  assign w_cnt   = r_wp - r_rp;
  assign w_full  = w_cnt[PW];
  assign w_empty = w_cnt == '0;
  assign w_head  = r_mem[r_rp[PW-1:0]];
  // jal wins when both type flags are set; a jal is always recorded as taken
  assign w_rec   = {cm_is_jal, cm_is_jal | cm_taken, cm_target, cm_pc};
  assign cm_ready  = w_clear || !w_full;
  assign btb_wr_en = !w_clear && !w_empty;
  assign w_cf    = cm_valid && cm_ready && (cm_is_br || cm_is_jal);
  assign w_deq   = btb_wr_en && btb_wr_ready;
  assign w_flush = !w_clear && inv_req;
  assign w_enq   = w_cf && !w_clear && !inv_req;
  assign w_add   = (w_clear || w_flush ? AW'(w_cf) : '0) + (w_flush ? AW'(w_cnt) - AW'(w_deq) : '0);
  assign w_sum   = 9'(r_drop) + 9'(w_add);
  assign btb_wr_pc     = btb_wr_en ? w_head[31:0]  : '0;
  assign btb_wr_target = btb_wr_en ? w_head[63:32] : '0;
  assign btb_wr_taken  = btb_wr_en && w_head[64];
  assign btb_wr_jal    = btb_wr_en && w_head[65];
  assign btb_clr_en  = w_clear;
  assign btb_clr_idx = r_idx;
  assign inv_busy    = w_clear;
  assign fetch_hold  = w_clear;
  assign drop_cnt    = r_drop;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_idx   <= '0;
      r_drop  <= '0;
    end else begin
      r_drop <= w_sum[8] ? 8'hFF : w_sum[7:0];
      if (w_clear) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        if (r_idx == IDX_LAST) r_state <= IDLE;
      end else if (inv_req) begin
        r_state <= CLEAR;
        r_wp    <= '0;
        r_rp    <= '0;
      end else begin
        if (w_enq) r_mem[r_wp[PW-1:0]] <= w_rec;
        if (w_enq) r_wp <= r_wp + 1'b1;
        if (w_deq) r_rp <= r_rp + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: queue-based reference model with a scoreboard monitor on the BTB write port
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cm_valid, cm_ready, cm_is_br, cm_is_jal, cm_taken, inv_req, inv_busy;
  logic [31:0] cm_pc, cm_target, btb_wr_pc, btb_wr_target;
  logic        btb_wr_en, btb_wr_ready, btb_wr_taken, btb_wr_jal, btb_clr_en, fetch_hold;
  logic [4:0]  btb_clr_idx;
  logic [7:0]  drop_cnt;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc),
    .cm_target(cm_target), .cm_is_br(cm_is_br), .cm_is_jal(cm_is_jal), .cm_taken(cm_taken),
    .inv_req(inv_req), .inv_busy(inv_busy), .btb_wr_en(btb_wr_en), .btb_wr_ready(btb_wr_ready),
    .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken),
    .btb_wr_jal(btb_wr_jal), .btb_clr_en(btb_clr_en), .btb_clr_idx(btb_clr_idx),
    .fetch_hold(fetch_hold), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] tgt; logic tk; logic jal;} rec_t;
  rec_t mq[$];
  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_clear = 0;
  int   m_idx = 0;
  int   m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && btb_wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        chk("wr_pc", btb_wr_pc, exp_q[0].pc);
        chk("wr_target", btb_wr_target, exp_q[0].tgt);
        chk("wr_taken", 32'(btb_wr_taken), 32'(exp_q[0].tk));
        chk("wr_jal", 32'(btb_wr_jal), 32'(exp_q[0].jal));
        if (btb_wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic br, input logic jl, input logic tk,
                      input logic inv, input logic wr, input logic [31:0] pc);
    bit   ready, wen, cf, deq;
    int   sum;
    rec_t r;
    cm_valid = v; cm_is_br = br; cm_is_jal = jl; cm_taken = tk;
    cm_pc = pc; cm_target = $urandom; inv_req = inv; btb_wr_ready = wr;
    ready = m_clear || mq.size() < 4;
    wen   = !m_clear && mq.size() != 0;
    cf    = v && ready && (br || jl);
    deq   = wen && wr;
    r.pc = cm_pc; r.tgt = cm_target; r.jal = jl; r.tk = jl ? 1'b1 : tk;
    @(negedge clk);
    if (rst) begin
      chk("cm_ready", 32'(cm_ready), 32'(ready));
      chk("btb_wr_en", 32'(btb_wr_en), 32'(wen));
      chk("btb_clr_en", 32'(btb_clr_en), 32'(m_clear));
      chk("btb_clr_idx", 32'(btb_clr_idx), m_clear ? m_idx : 0);
      chk("inv_busy", 32'(inv_busy), 32'(m_clear));
      chk("fetch_hold", 32'(fetch_hold), 32'(m_clear));
      chk("drop_cnt", 32'(drop_cnt), m_drop);
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete(); exp_q.delete(); m_clear = 0; m_idx = 0; m_drop = 0;
    end else if (m_clear) begin
      sum = m_drop + int'(cf);
      m_drop = sum > 255 ? 255 : sum;
      if (m_idx == 31) begin m_clear = 0; m_idx = 0; end
      else m_idx++;
    end else if (inv) begin
      sum = m_drop + mq.size() - int'(deq) + int'(cf);
      m_drop = sum > 255 ? 255 : sum;
      mq.delete(); exp_q.delete(); m_clear = 1; m_idx = 0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (cf) begin mq.push_back(r); exp_q.push_back(r); end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    cm_valid = 0; cm_is_br = 0; cm_is_jal = 0; cm_taken = 0; cm_pc = 0; cm_target = 0;
    inv_req = 0; btb_wr_ready = 0;
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, i != 1, 0, 1, 32'h100 + 32'(4 * i));
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1'($urandom), 0, 0, $urandom);
    repeat (5) step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 32'h200);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0, 0, $urandom);
    step(1, 0, 1, 0, 0, 0, $urandom);
    step(1, 1, 0, 0, 1, 0, $urandom);
    chk("drop_after_flush", 32'(drop_cnt), 32'd3);
    repeat (33) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    repeat (10) step(0, 0, 0, 0, 0, 1, 0);
    chk("clr_idx_before_rst", 32'(btb_clr_idx), 32'd10);
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 800; i++)
      step($urandom % 4 != 0, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom % 50 == 0, $urandom % 3 != 0, $urandom);
    do_reset();
    n = 0;
    while (m_drop < 254 && n < 3000) begin
      step(1, 1, 0, 1, !m_clear, 1, $urandom);
      n++;
    end
    chk("preload_254", 32'(drop_cnt), 32'd254);
    n = 0;
    while (m_clear && n < 40) begin step(0, 0, 0, 0, 0, 0, 0); n++; end
    repeat (4) step(1, 0, 1, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    repeat (10) step(1, 1, 0, 1, 0, 1, $urandom);
    chk("drop_stays_255", 32'(drop_cnt), 32'd255);
    repeat (30) step(0, 0, 0, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
